// File: rtl/npu_pkg.sv
// Shared types and elaboration-time helpers for the NPU row controller slice.
package npu_pkg;

    typedef enum logic [1:0] {
        MODE_MAX    = 2'd0,
        MODE_MIN    = 2'd1,
        MODE_ARGMAX = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_COMPUTE,
        ST_REDUCE,
        ST_SEND,
        ST_DONE
    } state_e;

    // Never returns 0 so the result is always usable as a vector width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/npu_reduce_unit.sv
// Sequential compare/select over the engine results; tracks the winning value and its index.
module npu_reduce_unit
    import npu_pkg::*;
#(
    parameter int NUM_RES = 30,
    parameter int RES_W   = 18,
    parameter int CNT_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic [CNT_W-1:0]         i_count,
    input  mode_e                    i_mode,
    input  logic [NUM_RES*RES_W-1:0] i_results,
    output logic [RES_W-1:0]         o_best,
    output logic [CNT_W-1:0]         o_idx
);

    logic signed [RES_W-1:0] r_best;
    logic        [CNT_W-1:0] r_idx;
    logic signed [RES_W-1:0] w_cand;
    logic                    w_better;

    always_comb begin
        w_cand   = '0;
        w_better = 1'b0;
        for (int unsigned i = 0; i < NUM_RES; i++) begin
            if (i_count == CNT_W'(i)) w_cand = i_results[i*RES_W +: RES_W];
        end
        // Strict compares keep the earliest winner on ties; ARGMAX ranks like MAX.
        case (i_mode)
            MODE_MIN: w_better = (w_cand < r_best);
            default:  w_better = (w_cand > r_best);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_best <= i_results[RES_W-1:0];
            r_idx  <= '0;
        end else if (i_step && w_better) begin
            r_best <= w_cand;
            r_idx  <= i_count;
        end
    end

    assign o_best = r_best;
    assign o_idx  = r_idx;

endmodule

// File: rtl/npu_row_controller.sv
// Row controller: collects a pixel row, launches the conv engine, reduces its results
// and streams the answer out LSB byte first with valid/ready backpressure.
module npu_row_controller
    import npu_pkg::*;
#(
    parameter int ROW_LEN = 32,
    parameter int PIX_W   = 8,
    parameter int KERNEL  = 3,
    parameter int RES_W   = 18
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [1:0]                            mode,
    input  logic [PIX_W-1:0]                      rx_data,
    input  logic                                  rx_valid,
    output logic                                  rx_ready,
    output logic                                  eng_start,
    output logic [ROW_LEN*PIX_W-1:0]              eng_pixels,
    input  logic                                  eng_done,
    input  logic [(ROW_LEN-KERNEL+1)*RES_W-1:0]   eng_results,
    output logic [7:0]                            tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int NUM_RES  = ROW_LEN - KERNEL + 1;
    localparam int TX_BYTES = int'(ceil_div(RES_W, 8));
    localparam int CNT_W    = int'(clog2(ROW_LEN + 1));
    localparam int BC_W     = int'(clog2(TX_BYTES));
    localparam int TXW      = TX_BYTES * 8;

    state_e                     r_state, w_next;
    mode_e                      r_mode;
    logic [CNT_W-1:0]           r_count;
    logic [BC_W-1:0]            r_bcnt;
    logic                       r_eng_start;
    logic [ROW_LEN*PIX_W-1:0]   r_pix;

    logic                       w_rx_beat, w_last_pix, w_last_res;
    logic                       w_tx_hs, w_last_byte, w_load, w_step;
    logic [RES_W-1:0]           w_best;
    logic [CNT_W-1:0]           w_idx;
    logic [TXW-1:0]             w_word;
    logic [7:0]                 w_tx_byte;

    assign w_rx_beat   = (r_state == ST_RECEIVE) && rx_valid;
    assign w_last_pix  = (r_count == CNT_W'(ROW_LEN - 1));
    assign w_last_res  = (r_count == CNT_W'(NUM_RES - 1));
    assign w_tx_hs     = (r_state == ST_SEND) && tx_ready;
    assign w_last_byte = (r_bcnt == BC_W'(TX_BYTES - 1));
    assign w_load      = (r_state == ST_COMPUTE) && eng_done;
    assign w_step      = (r_state == ST_REDUCE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                rx_ready = 1'b1;
                if (w_rx_beat && w_last_pix) w_next = ST_COMPUTE;
            end
            ST_COMPUTE: if (eng_done) w_next = ST_REDUCE;
            ST_REDUCE:  if (w_last_res) w_next = ST_SEND;
            ST_SEND: begin
                tx_valid = 1'b1;
                if (w_tx_hs && w_last_byte) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= MODE_MAX;
            r_count     <= '0;
            r_bcnt      <= '0;
            r_eng_start <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_eng_start <= w_rx_beat && w_last_pix;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode_e'(mode);
                        r_count <= '0;
                    end
                end
                ST_RECEIVE: begin
                    if (w_rx_beat) begin
                        for (int unsigned i = 0; i < ROW_LEN; i++) begin
                            if (r_count == CNT_W'(i)) r_pix[i*PIX_W +: PIX_W] <= rx_data;
                        end
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                ST_COMPUTE: if (eng_done) r_count <= CNT_W'(1);
                ST_REDUCE: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_last_res) r_bcnt <= '0;
                end
                ST_SEND: begin
                    if (w_tx_hs) r_bcnt <= w_last_byte ? '0 : r_bcnt + BC_W'(1);
                end
                default: ;
            endcase
        end
    end

    npu_reduce_unit #(
        .NUM_RES (NUM_RES),
        .RES_W   (RES_W),
        .CNT_W   (CNT_W)
    ) u_reduce (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_count   (r_count),
        .i_mode    (r_mode),
        .i_results (eng_results),
        .o_best    (w_best),
        .o_idx     (w_idx)
    );

    // Value modes sign-extend the winner; ARGMAX reports the zero-extended index.
    always_comb begin
        w_word = {TXW{w_best[RES_W-1]}};
        w_word[RES_W-1:0] = w_best;
        if (r_mode == MODE_ARGMAX) w_word = TXW'(w_idx);
        w_tx_byte = '0;
        for (int unsigned i = 0; i < TX_BYTES; i++) begin
            if (r_bcnt == BC_W'(i)) w_tx_byte = w_word[i*8 +: 8];
        end
    end

    assign tx_data    = tx_valid ? w_tx_byte : '0;
    assign eng_start  = r_eng_start;
    assign eng_pixels = r_pix;

endmodule

// File: tb/tb_npu_row_controller.sv
// Directed, table-driven bench for npu_row_controller with an inline conv-engine model.
module tb_npu_row_controller;

    localparam int ROW_LEN = 32;
    localparam int PIX_W   = 8;
    localparam int KERNEL  = 3;
    localparam int RES_W   = 18;
    localparam int NUM_RES = ROW_LEN - KERNEL + 1;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         start = 1'b0;
    logic [1:0]                   mode = 2'd0;
    logic [PIX_W-1:0]             rx_data = '0;
    logic                         rx_valid = 1'b0;
    logic                         rx_ready;
    logic                         eng_start;
    logic [ROW_LEN*PIX_W-1:0]     eng_pixels;
    logic                         eng_done = 1'b0;
    logic [NUM_RES*RES_W-1:0]     eng_results = '0;
    logic [7:0]                   tx_data;
    logic                         tx_valid;
    logic                         tx_ready = 1'b0;
    logic                         busy;
    logic                         done;

    int checks   = 0;
    int failures = 0;

    npu_row_controller #(
        .ROW_LEN (ROW_LEN),
        .PIX_W   (PIX_W),
        .KERNEL  (KERNEL),
        .RES_W   (RES_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .eng_start   (eng_start),
        .eng_pixels  (eng_pixels),
        .eng_done    (eng_done),
        .eng_results (eng_results),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        bit          ramp;
        int          fill;
        int          i1;
        int          v1;
        int          i2;
        int          v2;
        logic [7:0]  seed;
        bit          gaps;
        int          stall;
        bit          start_in_done;
        logic [23:0] exp_word;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_results(input vec_t v);
        int val;
        for (int i = 0; i < NUM_RES; i++) begin
            val = v.ramp ? (10 * i - 100) : v.fill;
            if (i == v.i1) val = v.v1;
            if (i == v.i2) val = v.v2;
            eng_results[i*RES_W +: RES_W] = 18'(val);
        end
    endtask

    task automatic send_row(input logic [7:0] seed, input bit gaps, output logic [255:0] exp_pix);
        exp_pix = '0;
        for (int p = 0; p < ROW_LEN; p++) begin
            if (gaps && p > 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'hAA;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = 8'(p) ^ seed;
            exp_pix[p*8 +: 8] = 8'(p) ^ seed;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        logic [255:0] exp_pix;
        int lat;
        load_results(v);
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        @(negedge clk);
        start = 1'b0;
        mode  = ~v.mode;
        chk("rx_ready_in_receive", rx_ready, 1);
        chk("busy_in_receive", busy, 1);
        send_row(v.seed, v.gaps, exp_pix);
        chk("eng_start_after_last_beat", eng_start, 1);
        chk("rx_ready_after_last_beat", rx_ready, 0);
        chk("eng_pixels", eng_pixels, exp_pix);
        if (v.seed == 8'h00 && v.gaps) begin
            chk("eng_pixels_first", eng_pixels[7:0], 8'h00);
            chk("eng_pixels_last", eng_pixels[255:248], 8'h1F);
        end
        @(negedge clk);
        chk("eng_start_single_pulse", eng_start, 0);
        repeat (2) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        lat = 0;
        while (!tx_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("reduce_latency", 32'(lat), 32'(NUM_RES - 1));
        for (int b = 0; b < 3; b++) begin
            if (b == 0) begin
                for (int s = 0; s < v.stall; s++) begin
                    tx_ready = 1'b0;
                    @(negedge clk);
                    chk("stall_tx_valid", tx_valid, 1);
                    chk("stall_tx_data", tx_data, v.exp_word[7:0]);
                end
            end
            tx_ready = 1'b1;
            chk("tx_valid", tx_valid, 1);
            chk($sformatf("tx_byte%0d", b), tx_data, v.exp_word[b*8 +: 8]);
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("tx_valid_after_last", tx_valid, 0);
        if (v.start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [255:0] pix;
        int seen;
        //          mode  ramp fill  i1  v1       i2  v2   seed   gaps stall sid  exp
        tbl[0] = '{2'd0, 1'b1,   0, 17,  131071, -1,   0, 8'h00, 1'b1, 5, 1'b0, 24'h01FFFF};
        tbl[1] = '{2'd1, 1'b0,   5,  5, -131072, -1,   0, 8'h5A, 1'b0, 0, 1'b0, 24'hFE0000};
        tbl[2] = '{2'd2, 1'b0,   0,  3,     500, 20, 500, 8'hC3, 1'b1, 2, 1'b1, 24'h000003};
        tbl[3] = '{2'd3, 1'b1,   0, -1,       0, -1,   0, 8'h11, 1'b0, 0, 1'b0, 24'h0000BE};
        tbl[4] = '{2'd1, 1'b1,   0, -1,       0, -1,   0, 8'hFF, 1'b0, 1, 1'b0, 24'hFFFF9C};
        tbl[5] = '{2'd2, 1'b1,   0, 29,      -5, -1,   0, 8'h33, 1'b0, 0, 1'b0, 24'h00001C};
        tbl[6] = '{2'd0, 1'b0,  -7, -1,       0, -1,   0, 8'h0F, 1'b0, 0, 1'b0, 24'hFFFFF9};
        tbl[7] = '{2'd2, 1'b0,  -1, 29,       0, -1,   0, 8'h80, 1'b0, 0, 1'b0, 24'h00001D};
        tbl[8] = '{2'd1, 1'b0, 100,  0,      -3, 29,  -3, 8'h44, 1'b0, 0, 1'b0, 24'hFFFFFD};
        tbl[9] = '{2'd0, 1'b0,   0,  0,       7, -1,   0, 8'h21, 1'b0, 0, 1'b0, 24'h000007};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_rx_ready", rx_ready, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_eng_start", eng_start, 0);
        chk("reset_done", done, 0);
        chk("reset_eng_pixels", eng_pixels, 0);

        for (int t = 0; t < 10; t++) run_row(tbl[t]);

        // Ignored start during COMPUTE, then an abort by reset before eng_done.
        load_results(tbl[1]);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd1;
        @(negedge clk);
        start = 1'b0;
        send_row(8'h77, 1'b0, pix);
        chk("abort_eng_start", eng_start, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_compute_busy", busy, 1);
        chk("start_in_compute_rx_ready", rx_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_tx_data", tx_data, 0);
        chk("abort_eng_start_clr", eng_start, 0);
        chk("abort_done", done, 0);
        chk("abort_eng_pixels", eng_pixels, 0);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (tx_valid || busy) seen++;
            @(negedge clk);
        end
        chk("late_eng_done_ignored", 32'(seen), 0);

        run_row(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
